// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment display blocks
package seg_pkg;
    localparam int   DEF_NUM_DIGITS = 4;
    localparam int   NIB_W          = 4;
    localparam logic ANODE_OFF      = 1'b1;
    localparam logic ANODE_ON       = 1'b0;
    localparam logic DP_ON          = 1'b1;
    localparam logic DP_OFF         = 1'b0;
endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: modulo-DIV counter producing a one-cycle tick at terminal count
module scan_tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    logic [CW-1:0] cnt;
    assign tick = cnt == CW'(DIV - 1);
    // count 0..DIV-1 and wrap on the tick
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else     cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: double-buffered multiplexed scan controller for a seven-segment display
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        load,
    input  logic [NIB_W*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    output logic [NIB_W-1:0]            digit,
    output logic                        dp_enable,
    output logic [NUM_DIGITS-1:0]       an,
    output logic                        frame_start
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int W  = NIB_W * NUM_DIGITS;
    logic                  tick, wrap, pending, nz;
    logic [IW-1:0]         idx, idx_nxt;
    logic [W-1:0]          shadow, active, act_nxt;
    logic [NUM_DIGITS-1:0] shadow_dp, active_dp, dp_nxt, blank, an_nxt;
    logic [NIB_W-1:0]      dig_nxt;

    scan_tick_gen #(.DIV(REFRESH_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // next index/frame contents so the registered outputs track the index with zero latency
    always_comb begin
        wrap    = tick && idx == IW'(NUM_DIGITS - 1);
        idx_nxt = wrap ? '0 : tick ? idx + 1'b1 : idx;
        act_nxt = (wrap && pending) ? shadow : active;
        dp_nxt  = (wrap && pending) ? shadow_dp : active_dp;
        dig_nxt = act_nxt[NIB_W*idx_nxt +: NIB_W];
        nz      = 1'b0;
        blank   = '0;
        an_nxt  = {NUM_DIGITS{ANODE_OFF}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz        = nz | (act_nxt[NIB_W*i +: NIB_W] != '0) | dp_nxt[i];
            blank[i]  = (BLANK_LZ != 0) && (i != 0) && !nz;
            an_nxt[i] = (en && !blank[i] && idx_nxt == IW'(i)) ? ANODE_ON : ANODE_OFF;
        end
    end

    // scan state, double-buffered value registers and registered decoder outputs
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            idx         <= '0;
            shadow      <= '0;
            shadow_dp   <= '0;
            active      <= '0;
            active_dp   <= '0;
            pending     <= 1'b0;
            digit       <= '0;
            dp_enable   <= DP_OFF;
            an          <= {NUM_DIGITS{ANODE_OFF}};
            frame_start <= 1'b0;
        end else begin
            idx         <= idx_nxt;
            active      <= act_nxt;
            active_dp   <= dp_nxt;
            shadow      <= load ? value_in : shadow;
            shadow_dp   <= load ? dp_in : shadow_dp;
            pending     <= load ? 1'b1 : wrap ? 1'b0 : pending;
            digit       <= dig_nxt;
            dp_enable   <= dp_nxt[idx_nxt] ? DP_ON : DP_OFF;
            an          <= an_nxt;
            frame_start <= wrap;
        end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed self-checking bench for the scan controller
module tb_seven_seg_scanner;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit;
    logic        dp_enable;
    logic [3:0]  an;
    logic        frame_start;
    int          passed = 0;
    int          total = 0;

    seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .value_in    (value_in),
        .dp_in       (dp_in),
        .digit       (digit),
        .dp_enable   (dp_enable),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // advance to the next negedge at which frame_start is seen, bounded
    task automatic wait_fs(output bit ok);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 40);
        ok = frame_start;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        total++; if (an !== 4'b1111) $display("FAIL reset_an got %b want 1111", an); else passed++;
        total++; if (digit !== 4'h0) $display("FAIL reset_digit got %h want 0", digit); else passed++;
        total++; if (dp_enable !== 1'b0) $display("FAIL reset_dp got %b want 0", dp_enable); else passed++;
        total++; if (frame_start !== 1'b0) $display("FAIL reset_fs got %b want 0", frame_start); else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (an !== 4'b1110) $display("FAIL post_reset_an got %b want 1110", an); else passed++;
        total++; if (digit !== 4'h0) $display("FAIL post_reset_digit got %h want 0", digit); else passed++;
    endtask

    task automatic test_scan();
        bit ok;
        int s;
        value_in = 16'h1234;
        dp_in = 4'b0000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_fs(ok);
        total++; if (!ok) $display("FAIL scan_wait got timeout want frame_start"); else passed++;
        for (int k = 0; k < 17; k++) begin
            if (k > 0) @(negedge clk);
            s = (k / 4) % 4;
            total++; if (an !== ~(4'b0001 << s)) $display("FAIL scan_an k=%0d got %b want %b", k, an, ~(4'b0001 << s)); else passed++;
            total++; if (digit !== 4'(s + 4 - 2 * s - (s > 0 ? 0 : 0))) $display("FAIL scan_digit k=%0d got %h want %h", k, digit, 4'(4 - s)); else passed++;
            total++; if (frame_start !== (k % 16 == 0)) $display("FAIL scan_fs k=%0d got %b want %b", k, frame_start, k % 16 == 0); else passed++;
        end
    endtask

    task automatic test_midframe_load();
        bit ok;
        int s;
        logic [15:0] v;
        wait_fs(ok);
        total++; if (!ok) $display("FAIL mid_wait got timeout want frame_start"); else passed++;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            load = 1'b0;
            s = (k / 4) % 4;
            v = (k < 16) ? 16'h1234 : 16'hABCD;
            total++; if (an !== ~(4'b0001 << s)) $display("FAIL mid_an k=%0d got %b want %b", k, an, ~(4'b0001 << s)); else passed++;
            total++; if (digit !== v[4*s +: 4]) $display("FAIL mid_digit k=%0d got %h want %h", k, digit, v[4*s +: 4]); else passed++;
            total++; if (frame_start !== (k % 16 == 0)) $display("FAIL mid_fs k=%0d got %b want %b", k, frame_start, k % 16 == 0); else passed++;
            if (k == 8) begin
                value_in = 16'hABCD;
                load = 1'b1;
            end
        end
    endtask

    task automatic test_enable();
        bit ok;
        int s;
        logic [15:0] v = 16'hABCD;
        wait_fs(ok);
        total++; if (!ok) $display("FAIL en_wait got timeout want frame_start"); else passed++;
        for (int k = 0; k < 17; k++) begin
            if (k > 0) @(negedge clk);
            s = (k / 4) % 4;
            total++; if (an !== ((k >= 6 && k <= 15) ? 4'b1111 : ~(4'b0001 << s))) $display("FAIL en_an k=%0d got %b", k, an); else passed++;
            total++; if (digit !== v[4*s +: 4]) $display("FAIL en_digit k=%0d got %h want %h", k, digit, v[4*s +: 4]); else passed++;
            total++; if (frame_start !== (k % 16 == 0)) $display("FAIL en_fs k=%0d got %b want %b", k, frame_start, k % 16 == 0); else passed++;
            if (k == 5) en = 1'b0;
            if (k == 15) en = 1'b1;
        end
    endtask

    task automatic test_blank();
        bit ok;
        int s;
        for (int p = 0; p < 2; p++) begin
            wait_fs(ok);
            value_in = 16'h0005;
            dp_in = (p == 0) ? 4'b0000 : 4'b0100;
            load = 1'b1;
            @(negedge clk);
            load = 1'b0;
            wait_fs(ok);
            total++; if (!ok) $display("FAIL blank_wait p=%0d got timeout want frame_start", p); else passed++;
            for (int k = 0; k < 16; k++) begin
                if (k > 0) @(negedge clk);
                s = k / 4;
                if (p == 0) begin
                    total++; if (an !== (s == 0 ? 4'b1110 : 4'b1111)) $display("FAIL blank_an k=%0d got %b", k, an); else passed++;
                    total++; if (dp_enable !== 1'b0) $display("FAIL blank_dp k=%0d got %b want 0", k, dp_enable); else passed++;
                end else begin
                    total++; if (an !== (s < 3 ? ~(4'b0001 << s) : 4'b1111)) $display("FAIL blankdp_an k=%0d got %b", k, an); else passed++;
                    total++; if (dp_enable !== (s == 2)) $display("FAIL blankdp_dp k=%0d got %b want %b", k, dp_enable, s == 2); else passed++;
                end
                total++; if (digit !== (s == 0 ? 4'h5 : 4'h0)) $display("FAIL blank_digit p=%0d k=%0d got %h", p, k, digit); else passed++;
            end
        end
    endtask

    task automatic test_wrap_load();
        bit ok;
        int s;
        wait_fs(ok);
        total++; if (!ok) $display("FAIL wrap_wait got timeout want frame_start"); else passed++;
        value_in = 16'h1111;
        dp_in = 4'b0000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (14) @(negedge clk);
        value_in = 16'h9999;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            s = (k / 4) % 4;
            total++; if (an !== ~(4'b0001 << s)) $display("FAIL wrap_an k=%0d got %b want %b", k, an, ~(4'b0001 << s)); else passed++;
            total++; if (digit !== (k < 16 ? 4'h1 : 4'h9)) $display("FAIL wrap_digit k=%0d got %h want %h", k, digit, k < 16 ? 4'h1 : 4'h9); else passed++;
            total++; if (frame_start !== (k % 16 == 0)) $display("FAIL wrap_fs k=%0d got %b want %b", k, frame_start, k % 16 == 0); else passed++;
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        wait_fs(ok);
        value_in = 16'h5678;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (an !== 4'b1111) $display("FAIL arst_an got %b want 1111", an); else passed++;
        total++; if (digit !== 4'h0) $display("FAIL arst_digit got %h want 0", digit); else passed++;
        total++; if (dp_enable !== 1'b0) $display("FAIL arst_dp got %b want 0", dp_enable); else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (an !== 4'b1110) $display("FAIL arst_rel_an got %b want 1110", an); else passed++;
        wait_fs(ok);
        total++; if (!ok) $display("FAIL arst_wait got timeout want frame_start"); else passed++;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            total++; if (digit !== 4'h0) $display("FAIL arst_digit k=%0d got %h want 0", k, digit); else passed++;
            total++; if (an !== ((k % 16) < 4 ? 4'b1110 : 4'b1111)) $display("FAIL arst_an k=%0d got %b", k, an); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_midframe_load();
        test_enable();
        test_blank();
        test_wrap_load();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
